// File: rtl/fifo_rd_fwft_pkg.sv
// Gray-code helpers shared by the read and write pointer stages of the async FIFO.
// Functions work on zero-extended 32-bit words so one definition serves any pointer width.
package fifo_rd_fwft_pkg;

  localparam int unsigned PTR_MAX = 32;

  typedef logic [PTR_MAX-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Upper zero bits contribute nothing to the prefix XOR, so narrower codes decode correctly.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX-1] = gray[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_fwft_gray2bin.sv
// Gray-to-binary decoder: each binary bit is the XOR of all gray bits at or above it.
module gray2bin #(
  parameter int N = 4
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^gray[N-1:i];
  end

endmodule

// File: rtl/fifo_rd_fwft.sv
// Read-domain controller of the async FIFO: read pointer, gray pointer for the write-side
// synchroniser, first-word-fall-through output register, and read-side occupancy flags.
module fifo_rd_fwft
  import fifo_rd_fwft_pkg::*;
#(
  parameter int P_SIZE    = 4,
  parameter int D_SIZE    = 8,
  parameter int AE_THRESH = 1
) (
  input  logic              r_clk,
  input  logic              r_rstn,
  input  logic [P_SIZE-1:0] sync_wr_ptr,
  input  logic [D_SIZE-1:0] r_data,
  input  logic              out_ready,
  output logic [P_SIZE-2:0] r_addr,
  output logic [P_SIZE-1:0] gray_rd_ptr,
  output logic [D_SIZE-1:0] out_data,
  output logic              out_valid,
  output logic              empty,
  output logic [P_SIZE-1:0] r_level,
  output logic              almost_empty
);

  localparam logic [P_SIZE-1:0] AE_LIMIT = P_SIZE'(AE_THRESH);

  logic [P_SIZE-1:0] r_ptr;
  logic [P_SIZE-1:0] r_ptr_next;
  logic [P_SIZE-1:0] gray_next;
  logic [P_SIZE-1:0] wr_bin;
  logic [P_SIZE-1:0] level_next;
  logic              ae_next;
  logic              pop;

  gray2bin #(.N(P_SIZE)) u_wr_decode (
    .gray (sync_wr_ptr),
    .bin  (wr_bin)
  );

  // Comparing gray codes directly avoids decoding the synchronised pointer on the flag path.
  assign empty  = (gray_rd_ptr == sync_wr_ptr);
  assign pop    = !empty && (!out_valid || out_ready);
  assign r_addr = r_ptr[P_SIZE-2:0];

  // NOTE: every signal gets a value on every pass through this block, so no latch is inferred.
  always_comb begin
    r_ptr_next = r_ptr + {{(P_SIZE-1){1'b0}}, pop};
    gray_next  = P_SIZE'(bin2gray(ptr_word_t'(r_ptr_next)));
    level_next = wr_bin - r_ptr_next;
    ae_next    = (level_next <= AE_LIMIT);
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values, whatever the order.
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      r_ptr       <= '0;
      gray_rd_ptr <= '0;
    end else begin
      r_ptr       <= r_ptr_next;
      gray_rd_ptr <= gray_next;
    end
  end

  // A pop both consumes the current word (if any) and refills the register in the same edge.
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (pop) begin
      out_data  <= r_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      r_level      <= '0;
      almost_empty <= 1'b1;
    end else begin
      r_level      <= level_next;
      almost_empty <= ae_next;
    end
  end

endmodule
